// File: rtl/sevenseg_scan_ctrl_if.sv
// Word-transfer channel into the seven-segment scan controller.
// The source drives word_in/word_valid and the controller answers with word_ready.
interface sevenseg_scan_ctrl_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// 8-digit time-multiplexed hex display scanner with frame-aligned word update.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module sevenseg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int DEAD_CYCLES  = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sevenseg_scan_ctrl_if.slave        word_if,
  input  logic                       enable,
  output logic [3:0]                 bcd_out,
  output logic [7:0]                 an,
  output logic [2:0]                 digit_idx,
  output logic                       frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          pending_q, pending_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          frame_tick_q, frame_tick_d;
  logic          slot_last;
  logic          boundary;
  logic          xfer;
  logic [7:0]    blank;

  assign slot_last = (cnt_q == CNT_LAST);
  assign boundary  = slot_last && (idx_q == 3'd7);
  assign xfer      = word_if.word_valid && !pending_q;

  // Scan counters, handshake and frame-aligned shadow update.
  // A transfer needs pending_q = 0, so it never collides with the shadow load.
  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pend_data_d  = pend_data_q;
    pending_d    = pending_q;
    frame_tick_d = boundary;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    if (boundary && pending_q) begin
      shadow_d  = pend_data_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      pend_data_d = word_if.word_in;
      pending_d   = 1'b1;
    end
  end

  // Blanking flags follow the word that will be shown after this edge.
  genvar gi;
  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_blank
`ifdef LEADING_ZERO_BLANK_EN
      assign blank[gi] = (shadow_d[31:4*gi] == '0);
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    an_d  = 8'hFF;
    bcd_d = shadow_d[{idx_d, 2'b00} +: 4];
    if ((cnt_d >= DEAD_CNT) && enable && !blank[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 32'd0;
      pend_data_q  <= 32'd0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      bcd_q        <= 4'd0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign word_if.word_ready = !pending_q;
  assign an                 = an_q;
  assign bcd_out            = bcd_q;
  assign digit_idx          = idx_q;
  assign frame_tick         = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with DIGIT_CYCLES = 4, DEAD_CYCLES = 1.
// Cycle N counts clock periods since reset release; outputs sampled 1 ns after the falling edge.
module tb_sevenseg_scan_ctrl;
  localparam int DC = 4;
  localparam int DD = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] bcd_out;
  logic [7:0] an;
  logic [2:0] digit_idx;
  logic       frame_tick;

  sevenseg_scan_ctrl_if wif ();

  sevenseg_scan_ctrl #(
    .DIGIT_CYCLES(DC),
    .DEAD_CYCLES (DD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_if   (wif.slave),
    .enable    (enable),
    .bcd_out   (bcd_out),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc;
  logic        en_applied;
  logic [31:0] exp_shadow;
  logic        exp_ready;
  logic [3:0]  seq_tbl [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle from the cycle number and the displayed word.
  task automatic check_cycle();
    int         cnt;
    int         idx;
    logic       blank;
    logic [7:0] an_e;
    logic [31:0] nib;
    cnt   = cyc % DC;
    idx   = (cyc / DC) % 8;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (exp_shadow >> (4 * idx)) == 32'd0) blank = 1'b1;
`endif
    an_e = 8'hFF;
    if (cnt >= DD && en_applied && !blank) an_e[idx] = 1'b0;
    nib = (exp_shadow >> (4 * idx)) & 32'hF;
    chk("an", {24'd0, an}, {24'd0, an_e});
    chk("bcd_out", {28'd0, bcd_out}, nib);
    chk("digit_idx", {29'd0, digit_idx}, idx);
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, (cyc > 0 && cyc % (8 * DC) == 0)});
    chk("word_ready", {31'd0, wif.word_ready}, {31'd0, exp_ready});
  endtask

  task automatic step();
    en_applied = enable;
    @(negedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n      = 1'b1;
    en_applied = enable;
    #1;
    cyc = 0;
    check_cycle();
  endtask

  initial begin
    seq_tbl[0] = 4'hD; seq_tbl[1] = 4'hC; seq_tbl[2] = 4'hB; seq_tbl[3] = 4'hA;
    seq_tbl[4] = 4'h4; seq_tbl[5] = 4'h3; seq_tbl[6] = 4'h2; seq_tbl[7] = 4'h1;
    rst_n          = 1'b0;
    enable         = 1'b1;
    wif.word_in    = 32'd0;
    wif.word_valid = 1'b0;
    cyc            = 0;
    exp_shadow     = 32'd0;
    exp_ready      = 1'b1;
    en_applied     = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_an", {24'd0, an}, 32'h0000_00FF);
    chk("rst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("rst_ready", {31'd0, wif.word_ready}, 32'd1);

    // Reset release, first transfer at cycle 2.
    release_reset();
    chk("c0_an", {24'd0, an}, 32'h0000_00FF);
    step();
    chk("c1_an", {24'd0, an}, 32'h0000_00FE);
    step();
    wif.word_in    = 32'h1234_ABCD;
    wif.word_valid = 1'b1;
    exp_ready      = 1'b0;
    step();
    wif.word_valid = 1'b0;
    run_to(5);
    chk("c5_an", {24'd0, an}, 32'h0000_00FD);
    run_to(31);
    exp_shadow = 32'h1234_ABCD;
    exp_ready  = 1'b1;
    step();
    chk("c32_tick", {31'd0, frame_tick}, 32'd1);
    step();
    chk("seq0", {28'd0, bcd_out}, {28'd0, seq_tbl[0]});

    // Fill pending with 0x11111111, then hold 0xFFFFFFFF while pending is full.
    wif.word_in    = 32'h1111_1111;
    wif.word_valid = 1'b1;
    exp_ready      = 1'b0;
    step();
    wif.word_in = 32'hFFFF_FFFF;
    for (int i = 1; i < 8; i++) begin
      run_to(33 + 4 * i);
      chk("seq", {28'd0, bcd_out}, {28'd0, seq_tbl[i]});
    end
    run_to(63);
    exp_shadow = 32'h1111_1111;
    exp_ready  = 1'b1;
    step();
    chk("c64_bcd", {28'd0, bcd_out}, 32'd1);
    exp_ready = 1'b0;
    step();
    wif.word_valid = 1'b0;

    // Display disabled for the whole frame starting at cycle 96.
    run_to(95);
    enable     = 1'b0;
    exp_shadow = 32'hFFFF_FFFF;
    exp_ready  = 1'b1;
    step();
    run_to(97);
    chk("dis_an", {24'd0, an}, 32'h0000_00FF);
    run_to(127);
    enable = 1'b1;
    step();
    chk("c128_tick", {31'd0, frame_tick}, 32'd1);

    // Load pending, then reset asynchronously mid-frame.
    wif.word_in    = 32'hCAFE_F00D;
    wif.word_valid = 1'b1;
    exp_ready      = 1'b0;
    step();
    wif.word_valid = 1'b0;
    run_to(142);
    chk("pre_rst_an", {24'd0, an}, 32'h0000_00F7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {24'd0, an}, 32'h0000_00FF);
    chk("arst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("arst_idx", {29'd0, digit_idx}, 32'd0);
    chk("arst_tick", {31'd0, frame_tick}, 32'd0);
    chk("arst_ready", {31'd0, wif.word_ready}, 32'd1);
    exp_shadow = 32'd0;
    exp_ready  = 1'b1;
    release_reset();
    run_to(33);
    chk("post_rst_bcd", {28'd0, bcd_out}, 32'd0);

    // Word with leading zeros.
    wif.word_in    = 32'h0000_0A05;
    wif.word_valid = 1'b1;
    exp_ready      = 1'b0;
    step();
    wif.word_valid = 1'b0;
    run_to(63);
    exp_shadow = 32'h0000_0A05;
    exp_ready  = 1'b1;
    step();
    run_to(73);
    chk("a05_d2_bcd", {28'd0, bcd_out}, 32'hA);
    chk("a05_d2_an", {24'd0, an}, 32'h0000_00FB);
    run_to(77);
`ifdef LEADING_ZERO_BLANK_EN
    chk("a05_d3_an", {24'd0, an}, 32'h0000_00FF);
`else
    chk("a05_d3_an", {24'd0, an}, 32'h0000_00F7);
`endif
    run_to(95);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display showing a 32-bit word as 8 hex nibbles. It accepts words through a valid/ready handshake and holds them in a pending register. A new word becomes visible only at a frame boundary, so no tearing is visible. Each cycle it selects one nibble for the downstream hex-to-segment decoder and drives the active-low anode lines with a configurable dead time between digits.

## Interface
- DIGIT_CYCLES, default 100000: clock cycles per digit slot; must be ≥ 2.
- DEAD_CYCLES, default 1000: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ DEAD_CYCLES < DIGIT_CYCLES.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- word_in  in  32  word to display; nibble i maps to digit i, where digit 0 is the rightmost digit.
- word_valid  in  1  word_in is offered this cycle.
- word_ready  out  1  the pending register can accept a word; equals !pending.
- enable  in  1  display enable; when low, all anodes are forced off while scanning continues.
- bcd_out  out  4  nibble of the current digit, fed to the segment decoder.
- an  out  8  anode selects, active low.
- digit_idx  out  3  index of the current digit.
- frame_tick  out  1  one-cycle pulse marking the first cycle of each frame.

## Operation
- State:
  - slot counter cnt, range 0..DIGIT_CYCLES-1, width $clog2(DIGIT_CYCLES);
  - digit index idx, range 0..7;
  - 32-bit shadow register (the displayed word);
  - 32-bit pending register with pending flag.
- Per-slot phases:
  - DEAD: cnt < DEAD_CYCLES; all an bits = 1.
  - ON: cnt ≥ DEAD_CYCLES; an[idx] = 0 if enable = 1 and the digit is not blanked.
- Scan sequencing:
  - cnt increments every cycle.
  - At cnt = DIGIT_CYCLES-1, cnt wraps to 0 and idx increments.
  - idx wraps from 7 to 0.
- Frame boundary = the edge where cnt = DIGIT_CYCLES-1 and idx = 7. At that edge:
  - if pending = 1: shadow ← pending register and pending ← 0;
  - frame_tick is high for the following cycle.
- Handshake:
  - A transfer occurs on an edge where word_valid = 1 and word_ready = 1; the pending register captures word_in and pending ← 1.
  - word_valid while word_ready = 0 is ignored; the source must hold the word.
  - Pending data is never overwritten.
- Simultaneous events: a transfer on the frame-boundary edge with pending = 0 fills pending. That word is shown at the next boundary, not the current one.
- Outputs:
  - bcd_out = shadow[4*idx +: 4]; digit_idx = idx.
  - All outputs are registered and computed from next-state values, so the value after an edge matches cnt/idx after that edge.
- Reset (asynchronous, rst_n low): cnt = 0, idx = 0, shadow = 0, pending = 0, word_ready = 1, an = 8'hFF, bcd_out = 0, digit_idx = 0, frame_tick = 0.
  - Reset mid-frame or mid-handshake discards both shadow and pending.
  - After reset release, the first cycle is digit 0, DEAD phase.

## Timing
- Frame length = 8 × DIGIT_CYCLES cycles.
- Anode low time per digit = DIGIT_CYCLES − DEAD_CYCLES cycles.
- Word latency: from accepting edge to visible at the next frame boundary; worst case 8 × DIGIT_CYCLES cycles.
- word_ready falls the cycle after a transfer. It rises the cycle after the frame-boundary edge that consumes the pending word.
- enable is sampled at each edge and takes effect on an in the next cycle. enable does not affect the counters or the handshake.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i ≥ 1) is blanked (an[i] stays 1 in its ON phase) when shadow[31:4*i] = 0. Digit 0 is never blanked, so word 0 shows a single "0".
- Not defined: all 8 digits light in their ON phase regardless of value.
- bcd_out and scan timing are identical in both builds.

## Test plan
All scenarios use DIGIT_CYCLES = 4 and DEAD_CYCLES = 1.
- Reset release with enable = 1:
  - an = FF on cycle 0;
  - an = FE on cycles 1–3;
  - an = FD on cycles 5–7;
  - frame_tick pulses at cycle 32;
  - bcd_out = 0 throughout.
- Transfer 0x1234ABCD at cycle 2: word_ready = 0 from cycle 3 until the cycle after the first boundary. After the boundary:
  - bcd_out sequences D, C, B, A, 4, 3, 2, 1 for digits 0–7;
  - word_ready returns to 1.
- Offer 0xFFFFFFFF while pending holds 0x11111111: 0xFFFFFFFF is not accepted; the next frame shows 0x11111111. The source holds valid, and the word is accepted the cycle after the boundary.
- enable = 0 for one full frame: an = FF throughout; frame_tick and idx continue on schedule.
- Assert rst_n low mid-frame with pending = 1: all outputs take reset values immediately (asynchronously); shadow and pending are cleared.
- With LEADING_ZERO_BLANK_EN, word 0x00000A05:
  - digits 0–2 light (5, 0, A);
  - an[7:3] stay 1;
  - word 0 lights only digit 0.
